// File: rtl/uart_pkg.sv
// Shared definitions for the UART <-> ALU command path: sequencer state
// encoding, default widths and the opcode values understood by the ALU.
package uart_pkg;

  localparam int unsigned DEF_N    = 8;
  localparam int unsigned DEF_OP_W = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } seq_state_t;

  localparam logic [DEF_OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_OP_W-1:0] OP_AND = 6'h24;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_OP_W-1:0] OP_NOR = 6'h27;
  localparam logic [DEF_OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [DEF_OP_W-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_if_timer.sv
// Inter-byte timeout counter. Counts while `run` is high, restarts on `clear`
// (a received byte) or whenever it is idle, and flags `expire` on the last
// cycle of the window unless a byte arrives in that same cycle.
module uart_if_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 5208000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = run && !clear && (count == LAST);

  // Free-running window counter, held at zero outside the waiting states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || clear || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_if.sv
// Command/result sequencer between UART RX/TX and the combinational ALU.
// Collects A, B and opcode bytes, runs the ALU, sends one result byte and
// waits for the transmitter before accepting the next command.
// Optional inter-byte timeout: define UART_ALU_IF_TIMEOUT_EN.
module uart_alu_if
  import uart_pkg::*;
#(
  parameter int unsigned N              = DEF_N,
  parameter int unsigned OP_W           = DEF_OP_W,
  parameter int unsigned TIMEOUT_CYCLES = 5208000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    rx_data,
  input  logic            rx_valid,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [N-1:0]    alu_result,
  output logic [N-1:0]    tx_data,
  output logic            tx_start,
  input  logic            tx_done,
  output logic            busy,
  output logic            overrun,
  output logic            timeout
);

  seq_state_t state, state_nxt;
  logic load_a, load_b, load_op, load_tx;
  logic to_expire;

`ifdef UART_ALU_IF_TIMEOUT_EN
  logic to_run;

  assign to_run = (state == WAIT_B) || (state == WAIT_OP);

  uart_if_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (to_run),
    .clear  (rx_valid),
    .expire (to_expire)
  );

  // One-cycle timeout pulse, aligned with the return to WAIT_A
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout <= 1'b0;
    else        timeout <= to_expire;
  end
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_A;
    else        state <= state_nxt;
  end

  // Next-state, register load strobes and Moore outputs
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    load_tx   = 1'b0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (rx_valid) begin
          load_a    = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_valid) begin
          load_b    = 1'b1;
          state_nxt = WAIT_OP;
        end else if (to_expire) begin
          state_nxt = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_valid) begin
          load_op   = 1'b1;
          state_nxt = EXEC;
        end else if (to_expire) begin
          state_nxt = WAIT_A;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        load_tx   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        tx_start  = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        if (tx_done) state_nxt = WAIT_A;
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  // Operand, opcode and result registers; each holds until reloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      if (load_a)  alu_a   <= rx_data;
      if (load_b)  alu_b   <= rx_data;
      if (load_op) alu_op  <= rx_data[OP_W-1:0];
      if (load_tx) tx_data <= alu_result;
    end
  end

  // Sticky overrun: any byte received while a command is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                overrun <= 1'b0;
    else if (rx_valid && busy) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed, table-driven bench for uart_alu_if with a small behavioural ALU.
module tb_uart_alu_if;

  localparam int unsigned N    = 8;
  localparam int unsigned OP_W = 6;
  localparam int unsigned TO_CYC = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rx_data;
  logic            rx_valid;
  logic [N-1:0]    alu_a, alu_b;
  logic [OP_W-1:0] alu_op;
  logic [N-1:0]    alu_result;
  logic [N-1:0]    tx_data;
  logic            tx_start;
  logic            tx_done;
  logic            busy;
  logic            overrun;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  uart_alu_if #(
    .N              (N),
    .OP_W           (OP_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"},   32'(alu_a),    32'h0);
    check({tag, "_alu_b"},   32'(alu_b),    32'h0);
    check({tag, "_alu_op"},  32'(alu_op),   32'h0);
    check({tag, "_tx_data"}, 32'(tx_data),  32'h0);
    check({tag, "_tx_start"},32'(tx_start), 32'h0);
    check({tag, "_busy"},    32'(busy),     32'h0);
    check({tag, "_overrun"}, 32'(overrun),  32'h0);
    check({tag, "_timeout"}, 32'(timeout),  32'h0);
  endtask

  // Sends a full command and checks the pipeline up to WAIT_TX; when
  // `finish` is set also completes the transfer with tx_done.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [5:0] exp_op, input logic [7:0] exp_res,
                         input logic exp_ovr, input bit finish);
    send_byte(a);
    check("wait_b_busy", 32'(busy), 32'h0);
    send_byte(b);
    send_byte(opb);
    // t+1: EXEC
    check("exec_busy",     32'(busy),     32'h1);
    check("exec_tx_start", 32'(tx_start), 32'h0);
    check("alu_a",         32'(alu_a),    32'(a));
    check("alu_b",         32'(alu_b),    32'(b));
    check("alu_op",        32'(alu_op),   32'(exp_op));
    tick();
    // t+2: SEND
    check("send_tx_start", 32'(tx_start), 32'h1);
    check("tx_data",       32'(tx_data),  32'(exp_res));
    tick();
    check("tx_start_width", 32'(tx_start), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_tx_no_restart", 32'(tx_start), 32'h0);
      check("wait_tx_busy",       32'(busy),     32'h1);
    end
    check("cmd_overrun", 32'(overrun), 32'(exp_ovr));
    if (finish) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("done_busy",    32'(busy),    32'h0);
      check("done_timeout", 32'(timeout), 32'h0);
      check("done_tx_data_hold", 32'(tx_data), 32'(exp_res));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, op: 6'h20, res: 8'h08};
    vecs[1] = '{a: 8'h10, b: 8'h07, opb: 8'hE0, op: 6'h20, res: 8'h17};
    vecs[2] = '{a: 8'h0A, b: 8'h03, opb: 8'h22, op: 6'h22, res: 8'h07};
    vecs[3] = '{a: 8'hF0, b: 8'h3C, opb: 8'h24, op: 6'h24, res: 8'h30};
    vecs[4] = '{a: 8'hF0, b: 8'h0F, opb: 8'h25, op: 6'h25, res: 8'hFF};
    vecs[5] = '{a: 8'hAA, b: 8'hFF, opb: 8'h66, op: 6'h26, res: 8'h55};
    vecs[6] = '{a: 8'h00, b: 8'h00, opb: 8'h27, op: 6'h27, res: 8'hFF};
    vecs[7] = '{a: 8'hFF, b: 8'h01, opb: 8'h20, op: 6'h20, res: 8'h00};

    reset    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Main table
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].op, vecs[i].res, 1'b0, 1'b1);
    end

    // Byte arriving in WAIT_TX is dropped and sets overrun
    run_cmd(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b0, 1'b0);
    send_byte(8'h11);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_still_busy", 32'(busy), 32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("ovr_idle", 32'(busy), 32'h0);
    run_cmd(8'h21, 8'h12, 8'h22, 6'h22, 8'h0F, 1'b1, 1'b1);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Reset after only the A byte
    send_byte(8'h77);
    check("partial_a", 32'(alu_a), 32'h77);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    #3;
    reset = 1'b1;
    tick();
    check_all_zero("post_reset");
    run_cmd(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b0, 1'b1);

    // Next A byte collides with tx_done
    run_cmd(8'h30, 8'h0C, 8'h24, 6'h24, 8'h00, 1'b0, 1'b0);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    check("b2b_overrun", 32'(overrun), 32'h1);
    check("b2b_idle",    32'(busy),    32'h0);
    run_cmd(8'h04, 8'h05, 8'h20, 6'h20, 8'h09, 1'b1, 1'b1);

`ifdef UART_ALU_IF_TIMEOUT_EN
    begin
      bit early;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      // Silence after A: timeout after exactly TO_CYC cycles in WAIT_B
      send_byte(8'h12);
      early = 1'b0;
      for (int i = 0; i < int'(TO_CYC) - 1; i++) begin
        tick();
        if (timeout !== 1'b0) early = 1'b1;
      end
      check("to_not_early", 32'(early), 32'h0);
      tick();
      check("to_pulse", 32'(timeout), 32'h1);
      tick();
      check("to_pulse_width", 32'(timeout), 32'h0);
      run_cmd(8'h21, 8'h22, 8'h20, 6'h20, 8'h43, 1'b0, 1'b1);

      // Byte on the expiry cycle wins
      send_byte(8'h40);
      for (int i = 0; i < int'(TO_CYC) - 1; i++) tick();
      send_byte(8'h34);
      check("to_race_no_pulse", 32'(timeout), 32'h0);
      check("to_race_alu_b",    32'(alu_b),   32'h34);
      send_byte(8'h20);
      check("to_race_exec", 32'(busy), 32'h1);
      tick();
      check("to_race_tx_data", 32'(tx_data), 32'h74);
      tx_done = 1'b1;
      tick();
      tick();
      tx_done = 1'b0;
      check("to_race_idle", 32'(busy), 32'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
